uart_transceiver: RTL and testbench

- Full-duplex 8N1 serial UART with a byte-wide valid/ready interface on each direction.
- Connects the on-chip byte world (CPU memory-mapped I/O, testbench byte driver) to the FPGA serial pins.
- A single instance serves as the CPU's console port.
- A second instance on the other end of the wires acts as host model in simulation.

---
 rtl/uart_transceiver_pkg.sv | 32 +++
 rtl/uart_receiver.sv | 139 +++++++++++++
 rtl/uart_transmitter.sv | 80 ++++++++
 rtl/uart_transceiver.sv | 45 ++++
 tb/tb_uart_transceiver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_transceiver_pkg.sv
// Shared constants, frame levels and FSM encodings for the 8N1 UART.
// Optional RX input synchronizer is selected elsewhere by UART_RX_SYNC_EN.
package uart_transceiver_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD_RATE  = 115_200;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_receiver.sv
// 8N1 receiver with mid-bit sampling, glitch rejection and framing-error discard.
// Define UART_RX_SYNC_EN to pass sin through a 2-flop synchronizer first.
module uart_receiver
  import uart_transceiver_pkg::*;
#(
  parameter int ClockFreq = DEFAULT_CLOCK_FREQ,
  parameter int BaudRate  = DEFAULT_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SampleTime     = SymbolEdgeTime / 2;
  localparam int CntW           = ctr_width(SymbolEdgeTime);
  localparam int IdxW           = ctr_width(DATA_BITS);
  localparam logic [CntW-1:0] CntLast  = CntW'(SymbolEdgeTime - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(SampleTime - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  logic sin_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], sin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign sin_s = sync_q[1];
`else
  assign sin_s = sin;
`endif

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (sin_s == START_BIT) begin
          cnt_d   = '0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = (sin_s == LINE_IDLE) ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {sin_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IdxLast) state_d = RX_STOP;
          else                  idx_d   = idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold off until the line is idle again.
        if (ferr_q) begin
          if (sin_s == LINE_IDLE) begin
            ferr_d  = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (sin_s == STOP_BIT) begin
            done    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A completing byte takes priority over a consume in the same cycle.
    valid_d = valid_q;
    dout_d  = dout_q;
    if (valid_q && data_out_ready) valid_d = 1'b0;
    if (done) begin
      valid_d = 1'b1;
      dout_d  = shift_q;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 transmitter: accepts one byte when idle and shifts out a 10-bit frame LSB first.
module uart_transmitter
  import uart_transceiver_pkg::*;
#(
  parameter int ClockFreq = DEFAULT_CLOCK_FREQ,
  parameter int BaudRate  = DEFAULT_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic                 sout
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int CntW           = ctr_width(SymbolEdgeTime);
  localparam int IdxW           = ctr_width(FRAME_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(SymbolEdgeTime - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  ready_q, ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shift_q <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      TX_IDLE: begin
        if (data_in_valid && ready_q) begin
          shift_d = {STOP_BIT, data_in, START_BIT};
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            state_d = TX_IDLE;
          end else begin
            shift_d = {LINE_IDLE, shift_q[FRAME_BITS-1:1]};
            idx_d   = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // Registered so that ready stays low for as long as reset is held.
    ready_d = (state_d == TX_IDLE);
  end

  assign data_in_ready = ready_q;
  assign sout          = (state_q == TX_SEND) ? shift_q[0] : LINE_IDLE;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// Define UART_RX_SYNC_EN when SIn is asynchronous to Clock.
module uart_transceiver
  import uart_transceiver_pkg::*;
#(
  parameter int ClockFreq = DEFAULT_CLOCK_FREQ,
  parameter int BaudRate  = DEFAULT_BAUD_RATE
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 DataInValid,
  output logic                 DataInReady,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 DataOutValid,
  input  logic                 DataOutReady,
  input  logic                 SIn,
  output logic                 SOut
);

  uart_transmitter #(
    .ClockFreq(ClockFreq),
    .BaudRate (BaudRate)
  ) u_tx (
    .clk          (Clock),
    .rst          (Reset),
    .data_in      (DataIn),
    .data_in_valid(DataInValid),
    .data_in_ready(DataInReady),
    .sout         (SOut)
  );

  uart_receiver #(
    .ClockFreq(ClockFreq),
    .BaudRate (BaudRate)
  ) u_rx (
    .clk           (Clock),
    .rst           (Reset),
    .sin           (SIn),
    .data_out      (DataOut),
    .data_out_valid(DataOutValid),
    .data_out_ready(DataOutReady)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Two transceivers cross-wired (A.SOut -> B.SIn, B.SOut -> A.SIn); A's serial output
// is checked every cycle against a frame-timeline model, received bytes against literals.
module tb_uart_transceiver;

  localparam int BIT   = 50_000_000 / 115_200;
  localparam int FRAME = 10 * BIT;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] a_din, b_din;
  logic a_vld, b_vld, a_ready, b_ready;
  logic [7:0] a_dout, b_dout;
  logic a_ovalid, b_ovalid, a_ordy, b_ordy;
  logic a_sout, b_sout, b_sin;
  logic b_sel, b_drv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign b_sin = b_sel ? b_drv : a_sout;

  uart_transceiver u_a (
    .Clock(clk), .Reset(rst),
    .DataIn(a_din), .DataInValid(a_vld), .DataInReady(a_ready),
    .DataOut(a_dout), .DataOutValid(a_ovalid), .DataOutReady(a_ordy),
    .SIn(b_sout), .SOut(a_sout)
  );

  uart_transceiver u_b (
    .Clock(clk), .Reset(rst),
    .DataIn(b_din), .DataInValid(b_vld), .DataInReady(b_ready),
    .DataOut(b_dout), .DataOutValid(b_ovalid), .DataOutReady(b_ordy),
    .SIn(b_sin), .SOut(b_sout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level on the line during frame bit idx: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Timeline model of A's transmitter, checked on every falling edge.
  logic       m_busy = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_elapsed = 0;
  logic       m_prev_rst = 1'b1;

  always @(negedge clk) begin
    logic exp_sout, exp_rdy;
    if (rst) begin
      exp_sout = 1'b1;
      exp_rdy  = 1'b0;
    end else if (m_busy) begin
      exp_sout = frame_bit(m_byte, m_elapsed / BIT);
      exp_rdy  = 1'b0;
    end else begin
      exp_sout = 1'b1;
      exp_rdy  = !m_prev_rst;
    end
    check("model_sout", {31'd0, a_sout}, {31'd0, exp_sout});
    check("model_ready", {31'd0, a_ready}, {31'd0, exp_rdy});
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_elapsed++;
      if (m_elapsed == FRAME) m_busy = 1'b0;
    end else if (a_vld && exp_rdy) begin
      m_busy    = 1'b1;
      m_byte    = a_din;
      m_elapsed = 0;
    end
    m_prev_rst = rst;
  end

  // All tasks are entered and left at posedge+#1.
  task automatic send_a(input logic [7:0] b);
    int n = 0;
    while (!a_ready && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready_wait", {31'd0, a_ready}, 32'd1);
    a_din = b;
    a_vld = 1'b1;
    @(posedge clk); #1;
    a_vld = 1'b0;
  endtask

  task automatic wait_a_idle();
    int n = 0;
    while (!a_ready && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    check("a_idle_wait", {31'd0, a_ready}, 32'd1);
  endtask

  task automatic wait_valid(input bit side_b, input logic [7:0] exp, input string name);
    int n = 0;
    while (!(side_b ? b_ovalid : a_ovalid) && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_valid"}, {31'd0, side_b ? b_ovalid : a_ovalid}, 32'd1);
    check({name, "_data"}, {24'd0, side_b ? b_dout : a_dout}, {24'd0, exp});
  endtask

  task automatic consume(input bit side_b, input string name);
    if (side_b) b_ordy = 1'b1; else a_ordy = 1'b1;
    @(posedge clk); #1;
    b_ordy = 1'b0;
    a_ordy = 1'b0;
    check({name, "_cleared"}, {31'd0, side_b ? b_ovalid : a_ovalid}, 32'd0);
  endtask

  task automatic drive_bit(input logic v);
    b_drv = v;
    repeat (BIT) begin
      @(posedge clk); #1;
    end
  endtask

  logic [9:0] exp_bits_0a = 10'b1000010100;
  logic [7:0] lb_bytes [3] = '{8'h41, 8'h00, 8'hff};
  logic [7:0] ferr_byte = 8'h33;

  initial begin
    int low_cnt;
    rst = 1'b0;
    a_din = 8'h00; b_din = 8'h00; a_vld = 1'b0; b_vld = 1'b0;
    a_ordy = 1'b0; b_ordy = 1'b0; b_sel = 1'b0; b_drv = 1'b1;
    #1 rst = 1'b1;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_sout", {31'd0, a_sout}, 32'd1);
    check("rst_ready", {31'd0, a_ready}, 32'd1);
    check("rst_b_valid", {31'd0, b_ovalid}, 32'd0);
    check("rst_b_dout", {24'd0, b_dout}, 32'h00);

    // Byte 0x0a: literal bit-centre levels and ready-low duration.
    send_a(8'h0a);
    low_cnt = 0;
    while (!a_ready && low_cnt < 2 * FRAME) begin
      if (low_cnt % BIT == BIT / 2 && low_cnt / BIT < 10) begin
        logic [9:0] eb;
        eb = exp_bits_0a;
        check($sformatf("tx0a_bit%0d", low_cnt / BIT), {31'd0, a_sout}, {31'd0, eb[low_cnt / BIT]});
      end
      @(posedge clk); #1;
      low_cnt++;
    end
    check("tx0a_ready_low_cycles", low_cnt, FRAME);
    check("rx0a_valid", {31'd0, b_ovalid}, 32'd1);
    check("rx0a_data", {24'd0, b_dout}, 32'h0a);
    consume(1'b1, "rx0a");

    // Loopback bytes with consume handshake.
    for (int i = 0; i < 3; i++) begin
      send_a(lb_bytes[i]);
      wait_valid(1'b1, lb_bytes[i], $sformatf("lb%0d", i));
      consume(1'b1, $sformatf("lb%0d", i));
    end
    wait_a_idle();

    // Overrun: second byte overwrites an unconsumed first.
    send_a(8'h55);
    send_a(8'haa);
    wait_a_idle();
    check("overrun_valid", {31'd0, b_ovalid}, 32'd1);
    check("overrun_data", {24'd0, b_dout}, 32'haa);
    consume(1'b1, "overrun");

    // Glitch on the line shorter than half a bit.
    b_sel = 1'b1;
    b_drv = 1'b0;
    repeat (100) @(posedge clk);
    #1 b_drv = 1'b1;
    repeat (FRAME) @(posedge clk);
    #1 check("glitch_no_byte", {31'd0, b_ovalid}, 32'd0);

    // Framing error: stop bit driven low.
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ferr_byte[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("ferr_no_byte", {31'd0, b_ovalid}, 32'd0);
    b_sel = 1'b0;
    send_a(8'h3c);
    wait_valid(1'b1, 8'h3c, "post_err");
    consume(1'b1, "post_err");
    wait_a_idle();

    // Reset in the middle of frame bit 4 (0x96 data bit 3 is 0).
    send_a(8'h96);
    repeat (4 * BIT + BIT / 2) @(posedge clk);
    #1 check("midrst_pre_sout", {31'd0, a_sout}, 32'd0);
    rst = 1'b1;
    #1 check("midrst_sout", {31'd0, a_sout}, 32'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", {31'd0, a_ready}, 32'd1);
    check("midrst_b_valid", {31'd0, b_ovalid}, 32'd0);
    send_a(8'hc3);
    wait_valid(1'b1, 8'hc3, "post_rst");
    consume(1'b1, "post_rst");
    wait_a_idle();

    // Both directions at once.
    a_din = 8'h81; b_din = 8'h7e;
    a_vld = 1'b1; b_vld = 1'b1;
    @(posedge clk); #1;
    a_vld = 1'b0; b_vld = 1'b0;
    wait_valid(1'b1, 8'h81, "duplex_ab");
    wait_valid(1'b0, 8'h7e, "duplex_ba");
    consume(1'b1, "duplex_ab");
    consume(1'b0, "duplex_ba");
    wait_a_idle();
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
